// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core definitions: execute sequencer state encoding,
// phase count and counter widths.
package pdp8_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_HOLD
    } seq_state_t;

    localparam int NPHASES = 5;
    localparam int PHASE_W = 3;
    localparam int SC_W    = 4;

endpackage

// File: rtl/phase_timer.sv
// Per-phase sub-counter for the execute sequencer: counts 0..CK_CYCLES,
// flags the first (sc==0) and strobe (sc==CK_CYCLES) cycles.
module phase_timer
    import pdp8_pkg::*;
#(
    parameter int CK_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic first,
    output logic last
);

    logic [SC_W-1:0] sc;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sc <= '0;
        end else if (enable) begin
            sc <= last ? '0 : sc + SC_W'(1);
        end
    end

    assign first = (sc == '0);
    assign last  = (sc == SC_W'(CK_CYCLES));

endmodule

// File: rtl/phase_sequencer.sv
// PDP-8 execute-phase sequencer: ck/stb timing for phases 1..5.
// Optional PHASE_SINGLE_STEP_EN adds a step input and a HOLD state.
module phase_sequencer
    import pdp8_pkg::*;
#(
    parameter int CK_CYCLES = 2,
    parameter int NPHASES   = pdp8_pkg::NPHASES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               done,
`ifdef PHASE_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [NPHASES-1:0] ck,
    output logic [NPHASES-1:0] stb,
    output logic               busy,
    output logic               finished,
    output logic               overrun
);

    seq_state_t         state;
    logic [PHASE_W-1:0] phase;
    logic               first;
    logic               last;
    logic               in_run;
    logic               stop;

    assign in_run = (state == SEQ_RUN);
    assign stop   = in_run && first && done;

    phase_timer #(
        .CK_CYCLES (CK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_run || stop),
        .enable (in_run),
        .first  (first),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEQ_IDLE;
            phase    <= PHASE_W'(1);
            finished <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            finished <= 1'b0;
            unique case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        overrun <= 1'b0;
                        phase   <= PHASE_W'(1);
                        state   <= SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (stop) begin
                        state    <= SEQ_IDLE;
                        phase    <= PHASE_W'(1);
                        finished <= 1'b1;
                    end else if (last) begin
                        if (phase == PHASE_W'(NPHASES)) begin
                            state    <= SEQ_IDLE;
                            phase    <= PHASE_W'(1);
                            finished <= 1'b1;
                            overrun  <= 1'b1;
                        end else begin
                            phase <= phase + PHASE_W'(1);
`ifdef PHASE_SINGLE_STEP_EN
                            state <= SEQ_HOLD;
`endif
                        end
                    end
                end
                SEQ_HOLD: begin
`ifdef PHASE_SINGLE_STEP_EN
                    if (step) begin
                        state <= SEQ_RUN;
                    end
`else
                    state <= SEQ_IDLE;
`endif
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        ck = '0;
        if (in_run) begin
            for (int i = 0; i < NPHASES; i++) begin
                ck[i] = (phase == PHASE_W'(i + 1));
            end
        end
    end

    assign stb  = last ? ck : '0;
    assign busy = (state != SEQ_IDLE);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with CK_CYCLES=2, default build.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [4:0] ck;
    logic [4:0] stb;
    logic       busy;
    logic       finished;
    logic       overrun;

    logic [4:0] done_mask;
    logic       done_force;

    int total = 0;
    int bad   = 0;

    assign done = done_force | (|(ck & done_mask));

    always #5 clk = ~clk;

    phase_sequencer #(
        .CK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .done     (done),
        .ck       (ck),
        .stb      (stb),
        .busy     (busy),
        .finished (finished),
        .overrun  (overrun)
    );

    // {ck, stb, busy, finished, overrun}
    typedef logic [12:0] obs_t;

    // Expected outputs in cycle t+i for a start at t; p = terminating
    // phase, 0 means no done (overrun).
    function automatic obs_t expect_at(int i, int p);
        logic [4:0] e_ck  = '0;
        logic [4:0] e_stb = '0;
        logic e_busy = 1'b0;
        logic e_fin  = 1'b0;
        logic e_ovr  = 1'b0;
        int last_busy = (p == 0) ? 15 : 3 * (p - 1) + 1;
        if (i >= 1 && i <= last_busy) begin
            e_ck   = 5'b00001 << ((i - 1) / 3);
            e_busy = 1'b1;
            if ((i - 1) % 3 == 2) e_stb = e_ck;
        end
        if (i == last_busy + 1) e_fin = 1'b1;
        if (p == 0 && i >= 16) e_ovr = 1'b1;
        return {e_ck, e_stb, e_busy, e_fin, e_ovr};
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        start      = 1'b0;
        done_force = 1'b0;
        done_mask  = '0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset;
        obs_t o;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        o = {ck, stb, busy, finished, overrun};
        total++;
        if (o !== 13'd0) begin
            bad++;
            $display("FAIL reset got=%b want=%b", o, 13'd0);
        end
        reset = 1'b0;
        next_cycle();
        o = {ck, stb, busy, finished, overrun};
        total++;
        if (o !== 13'd0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", o, 13'd0);
        end
    endtask

    task automatic test_two_phase;
        obs_t o, e;
        done_mask = 5'b00010;
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            start = 1'b0;
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 2);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL two_phase t+%0d got=%b want=%b", i, o, e);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_four_phase;
        obs_t o, e;
        done_mask = 5'b01000;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            next_cycle();
            start = 1'b0;
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 4);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL four_phase t+%0d got=%b want=%b", i, o, e);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_overrun;
        obs_t o, e;
        done_mask = '0;
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            start = 1'b0;
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overrun t+%0d got=%b want=%b", i, o, e);
            end
        end
        // restart in the finished cycle, then stop in phase 1
        start     = 1'b1;
        done_mask = 5'b00001;
        next_cycle();
        start = 1'b0;
        o = {ck, stb, busy, finished, overrun};
        e = {5'b00001, 5'b00000, 1'b1, 1'b0, 1'b0};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL restart t+17 got=%b want=%b", o, e);
        end
        next_cycle();
        o = {ck, stb, busy, finished, overrun};
        e = {5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL min_seq t+18 got=%b want=%b", o, e);
        end
        idle_cycles(2);
    endtask

    task automatic test_ignored_start;
        obs_t o, e;
        done_mask = 5'b00010;
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            start = (i <= 3);
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 2);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL ignored_start t+%0d got=%b want=%b", i, o, e);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_ignored_done;
        obs_t o, e;
        done_mask = '0;
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            start      = 1'b0;
            done_force = (i == 5);
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL ignored_done t+%0d got=%b want=%b", i, o, e);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid;
        obs_t o, e;
        done_mask = '0;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            start = 1'b0;
            o = {ck, stb, busy, finished, overrun};
            e = expect_at(i, 0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid t+%0d got=%b want=%b", i, o, e);
            end
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        o = {ck, stb, busy, finished, overrun};
        total++;
        if (o !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid t+6 got=%b want=%b", o, 13'd0);
        end
        next_cycle();
        o = {ck, stb, busy, finished, overrun};
        total++;
        if (o !== 13'd0) begin
            bad++;
            $display("FAIL reset_mid t+7 got=%b want=%b", o, 13'd0);
        end
        start     = 1'b1;
        done_mask = 5'b00001;
        next_cycle();
        start = 1'b0;
        o = {ck, stb, busy, finished, overrun};
        e = {5'b00001, 5'b00000, 1'b1, 1'b0, 1'b0};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_mid t+8 got=%b want=%b", o, e);
        end
        next_cycle();
        o = {ck, stb, busy, finished, overrun};
        e = {5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_mid t+9 got=%b want=%b", o, e);
        end
        idle_cycles(2);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        done_force = 1'b0;
        done_mask  = '0;
        #1;
        test_reset();
        test_two_phase();
        test_four_phase();
        test_overrun();
        test_ignored_start();
        test_ignored_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
